store_buffer: RTL
=================

# store_buffer

Posted-write store buffer between the processor's memory stage and the data memory. Stores retire into a small FIFO and drain to memory when the memory port is free. Loads are served either by youngest-match forwarding from the buffer or by a combinational read of memory. A flush handshake lets the halt path (instruction 0xFFFF) empty the buffer before memory contents are dumped.

## Interface
- DEPTH, 4: number of entries; power of two, minimum 2.
- AW, 16: address width.
- DW, 16: data width.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_we  in  1  store request this cycle.
- cpu_re  in  1  load request this cycle; never asserted together with cpu_we.
- cpu_addr  in  AW  load/store address.
- cpu_wdata  in  DW  store data.
- cpu_rdata  out  DW  load result, combinational.
- stall  out  1  processor must hold its memory stage this cycle.
- flush  in  1  drain request, level; held until flush_done.
- flush_done  out  1  buffer empty and flush asserted.
- mem_addr  out  AW  data memory address.
- mem_wdata  out  DW  data memory write data.
- mem_we  out  1  data memory write strobe.
- mem_ready  in  1  memory accepts a write this cycle.
- mem_rdata  in  DW  data memory read data, combinational.

## Operation
- State: circular FIFO of {addr, data}, head/tail pointers of log2(DEPTH) bits (natural wrap), count of log2(DEPTH)+1 bits.
- Port arbitration:
  - A load owns the memory port. mem_addr = cpu_addr, mem_we = 0.
  - Otherwise, if count != 0: mem_addr/mem_wdata = head entry, mem_we = 1.
  - Otherwise mem_we = 0.
- Drain: when mem_we && mem_ready, the head entry pops at the clock edge.
- Store accept: when cpu_we && !stall, the store pushes at the tail.
- Push and pop in the same cycle are legal; count is unchanged.
- stall = cpu_we && (count == DEPTH) && !(mem_we && mem_ready).
- A stalled store does not push. The processor re-presents it next cycle.
- Loads never stall.
- Load forwarding: all valid entries are compared with cpu_addr.
  - On any match, cpu_rdata is the data of the youngest matching entry.
  - Otherwise cpu_rdata = mem_rdata.
- No coalescing. Repeated stores to one address occupy separate entries and drain in program order.
- Flush:
  - While flush is high, cpu_we is ignored (no push).
  - Draining continues.
  - flush_done = flush && count == 0.
- Reset mid-operation: buffered stores are discarded, with no memory write.

## Timing
- Reset values:
  - Internal: count = 0, head = tail = 0.
  - Outputs: mem_we = 0, stall = 0, flush_done = 0, mem_addr = 0, mem_wdata = 0, cpu_rdata = mem_rdata.
- Store to memory latency: at least 1 cycle after acceptance. The entry is drained in the first cycle where it is at head, no load is present, and mem_ready = 1.
- Store-to-load forwarding is visible from the cycle after the store is accepted.
- Load latency is 0 cycles (combinational), both for a forward hit and for a memory read.
- Full + store + load: no drain is possible, so stall = 1.
- Full + store + drain accepted: no stall; count stays DEPTH.
- Empty + load: the memory read occurs and mem_we = 0.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Age order for forwarding is computed relative to head, not by raw index.
- stall, mem_we, mem_addr and cpu_rdata are combinational from state and inputs. There is no combinational path from mem_ready to cpu_rdata.

## Structure
- Shared package holds:
  - SB_DEPTH, SB_AW, SB_DW defaults.
  - The entry struct {addr, data}.
  - The pointer-width localparam, derived with $clog2.
- Sub-module store_buffer_match: takes entry addresses, a valid mask, head, and the query address. Returns a hit flag and the youngest-match index via an age-rotated priority encoder.
- Top-level logic: FIFO storage, pointers, arbitration, flush.

## Test plan
- Store 0x1234 to 0x0010, then load 0x0010 while mem_ready = 0 → cpu_rdata = 0x1234 from buffer; memory unchanged.
- Stores 0x0001 then 0x0002 to 0x0020, then load 0x0020 → cpu_rdata = 0x0002. After drain, memory[0x20] = 0x0002, written second.
- Fill 4 entries with mem_ready = 0, then store + load → stall = 1, count = 4. Raise mem_ready with no load → next store accepted, no stall.
- Continuous loads with 2 entries buffered → mem_we = 0 throughout. Entries drain in the first load-free cycles.
- 10 stores at mem_ready = 1 → pointers wrap. Memory receives the stores in order. Load of the oldest address after wrap returns the correct data.
- Buffer 3 stores, assert flush and drive cpu_we → no push occurs; flush_done rises when count = 0. Separately, assert rst_n = 0 with 2 entries → mem_we drops immediately and count = 0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared defaults and types for the posted-write store buffer.
package store_buffer_pkg;
   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 16;
   localparam int SB_DW    = 16;
   localparam int SB_PTR_W = $clog2(SB_DEPTH);

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;
endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match search over buffered store addresses, ordered by age from head.
module store_buffer_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int PW    = SB_PTR_W
) (
   input  logic [DEPTH-1:0][AW-1:0] addrs,
   input  logic [DEPTH-1:0]         valid,
   input  logic [PW-1:0]            head,
   input  logic [AW-1:0]            query,
   output logic                     hit,
   output logic [PW-1:0]            idx
);

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      logic [PW-1:0] p;
      hit = 1'b0;
      idx = head;
      p   = head;
      for (int k = 0; k < DEPTH; k++) begin
         p = head + PW'(k);
         if (valid[p] && (addrs[p] == query)) begin
            hit = 1'b1;
            idx = p;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of stores draining to data memory, with load forwarding.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_we,
   input  logic          cpu_re,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          stall,
   input  logic          flush,
   output logic          flush_done,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata
);

   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0][AW-1:0] addr_q;
   logic [DW-1:0]            data_q [DEPTH];
   logic [PW-1:0]            head;
   logic [PW-1:0]            tail;
   logic [PW:0]              count;
   logic [DEPTH-1:0]         valid;
   logic                     hit;
   logic [PW-1:0]            hit_idx;
   logic                     empty;
   logic                     full;
   logic                     push;
   logic                     pop;

   assign empty      = (count == '0);
   assign full       = (count == (PW+1)'(DEPTH));
   assign mem_we     = !cpu_re && !empty;
   assign mem_addr   = cpu_re ? cpu_addr : (empty ? '0 : addr_q[head]);
   assign mem_wdata  = empty ? '0 : data_q[head];
   assign pop        = mem_we && mem_ready;
   assign stall      = cpu_we && full && !pop;
   assign push       = cpu_we && !stall && !flush;
   assign flush_done = flush && empty;

   // An entry is live when its distance from head is below count.
   always_comb begin
      logic [PW-1:0] age;
      valid = '0;
      age   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age      = PW'(i) - head;
         valid[i] = ({1'b0, age} < count);
      end
   end

   store_buffer_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .PW    (PW)
   ) u_match (
      .addrs (addr_q),
      .valid (valid),
      .head  (head),
      .query (cpu_addr),
      .hit   (hit),
      .idx   (hit_idx)
   );

   assign cpu_rdata = hit ? data_q[hit_idx] : mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload needs no reset; entries are only observed through count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail] <= cpu_addr;
         data_q[tail] <= cpu_wdata;
      end
   end

endmodule
